// File: rtl/pwm_capture.sv
// pwm_capture: measures period and active-phase width of an external PWM
// waveform in prescaled ticks (tick every 2^prescale clk), so the results
// line up 1:1 with the generator's period/compare registers.
//
// state     | meaning
// ----------+------------------------------------------------------------
// IDLE      | capture disabled, counters held at zero
// WAIT_RISE | armed, discarding the partial cycle until the next rise
// MEAS_HIGH | counting period and active-phase ticks
// MEAS_LOW  | counting period ticks; next rise publishes the result
module pwm_capture #(
    parameter int CNT_W       = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             pwm_in,
    input  logic             en,
    input  logic             capture_reset,
    input  logic [7:0]       prescale,
    input  logic             active_high,
    output logic [CNT_W-1:0] period_out,
    output logic [CNT_W-1:0] high_out,
    output logic             meas_valid,
    output logic             locked,
    output logic             overflow
);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WAIT_RISE = 2'd1,
        MEAS_HIGH = 2'd2,
        MEAS_LOW  = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    state_t                 state_q, state_d;
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   pin_s, prev_q, rise, fall;
    logic [4:0]             p_q, p_clamp;
    logic [31:0]            pre_cnt_q, pre_eff, pre_mask;
    logic                   tick;
    logic [CNT_W-1:0]       per_q, per_d, hi_q, hi_d;
    logic [CNT_W-1:0]       edge_load;
    logic                   publish, sat;

    // pin synchroniser and one-cycle history for edge detection
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
            prev_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], pwm_in};
            prev_q <= pin_s;
        end
    end

    assign pin_s   = sync_q[SYNC_STAGES-1] ^ ~active_high;
    assign rise    = pin_s & ~prev_q;
    assign fall    = ~pin_s & prev_q;
    assign p_clamp = (prescale > 8'd31) ? 5'd31 : prescale[4:0];

    // shadow prescale tracks the input only while disarmed or on soft reset,
    // so a running measurement never sees its tick rate change
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            p_q <= '0;
        else if (capture_reset || !en)
            p_q <= p_clamp;
    end

    // the rise cycle is treated as count 0, so ticks are phase-locked to the pin
    assign pre_mask = (32'd1 << p_q) - 32'd1;
    assign pre_eff  = rise ? 32'd0 : pre_cnt_q;
    assign tick     = (pre_eff == pre_mask);
    assign edge_load = tick ? CNT_ONE : '0;

    // prescaler divider, restarted on every rise
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            pre_cnt_q <= '0;
        else if (capture_reset || state_q == IDLE)
            pre_cnt_q <= '0;
        else if (tick)
            pre_cnt_q <= '0;
        else
            pre_cnt_q <= pre_eff + 32'd1;
    end

    // FSM state and measurement counters
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            per_q   <= '0;
            hi_q    <= '0;
        end else begin
            state_q <= state_d;
            per_q   <= per_d;
            hi_q    <= hi_d;
        end
    end

    // next state, counter updates, publish and saturation decisions
    always_comb begin
        state_d = state_q;
        per_d   = per_q;
        hi_d    = hi_q;
        publish = 1'b0;
        sat     = 1'b0;
        if (capture_reset) begin
            state_d = en ? WAIT_RISE : IDLE;
            per_d   = '0;
            hi_d    = '0;
        end else if (!en) begin
            state_d = IDLE;
            per_d   = '0;
            hi_d    = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    state_d = WAIT_RISE;
                    per_d   = '0;
                    hi_d    = '0;
                end
                WAIT_RISE: begin
                    if (rise) begin
                        state_d = MEAS_HIGH;
                        per_d   = edge_load;
                        hi_d    = edge_load;
                    end
                end
                MEAS_HIGH: begin
                    if (tick && per_q == CNT_MAX) begin
                        sat = 1'b1;
                    end else if (tick) begin
                        per_d = per_q + CNT_ONE;
                        // the fall cycle belongs to the inactive phase
                        if (!fall)
                            hi_d = hi_q + CNT_ONE;
                    end
                    if (sat) begin
                        state_d = WAIT_RISE;
                        per_d   = '0;
                        hi_d    = '0;
                    end else if (fall) begin
                        state_d = MEAS_LOW;
                    end
                end
                MEAS_LOW: begin
                    if (rise) begin
                        publish = 1'b1;
                        state_d = MEAS_HIGH;
                        per_d   = edge_load;
                        hi_d    = edge_load;
                    end else if (tick && per_q == CNT_MAX) begin
                        sat     = 1'b1;
                        state_d = WAIT_RISE;
                        per_d   = '0;
                        hi_d    = '0;
                    end else if (tick) begin
                        per_d = per_q + CNT_ONE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // result registers and status flags
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            period_out <= '0;
            high_out   <= '0;
            meas_valid <= 1'b0;
            locked     <= 1'b0;
            overflow   <= 1'b0;
        end else if (capture_reset) begin
            period_out <= '0;
            high_out   <= '0;
            meas_valid <= 1'b0;
            locked     <= 1'b0;
            overflow   <= 1'b0;
        end else begin
            meas_valid <= publish;
            if (publish) begin
                period_out <= per_q;
                high_out   <= hi_q;
                locked     <= 1'b1;
            end
            if (sat) begin
                overflow <= 1'b1;
                locked   <= 1'b0;
            end
            if (!en)
                locked <= 1'b0;
        end
    end

endmodule
